mips_mc_controller: RTL and testbench

Multicycle control unit for the lab MIPS processor. It sits directly upstream of the ALU. It sequences fetch/decode/execute/memory/writeback and drives the 4-bit ALU operation code plus all datapath mux, enable and write strobes. It consumes the instruction opcode/funct fields and the ALU zero flag.

---
 rtl/mips_pkg.sv | 81 ++++++++
 rtl/alu_decoder.sv | 33 +++
 rtl/mips_mc_controller.sv | 141 ++++++++++++++
 tb/tb_mips_mc_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the lab MIPS multicycle core: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1010;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // What the current state asks of the ALU; FUNCT defers to the R-type table.
   typedef enum logic [1:0] {
      AC_ADD   = 2'd0,
      AC_SUB   = 2'd1,
      AC_FUNCT = 2'd2
   } alu_class_t;

   typedef struct packed {
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       illegal;
   } ctrl_t;

   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the state's ALU request class plus funct to a 4-bit ALU op; purely
// combinational, valid drops only for an unsupported R-type funct.
module alu_decoder
   import mips_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [5:0]  funct,
   output logic [3:0]  aluop,
   output logic        valid
);

   always_comb begin
      aluop = ALU_ADD;
      valid = 1'b1;
      case (alu_class)
         AC_SUB: aluop = ALU_SUB;
         AC_FUNCT: begin
            case (funct)
               FN_ADD:  aluop = ALU_ADD;
               FN_SUB:  aluop = ALU_SUB;
               FN_AND:  aluop = ALU_AND;
               FN_OR:   aluop = ALU_OR;
               FN_XOR:  aluop = ALU_XOR;
               FN_NOR:  aluop = ALU_NOR;
               FN_SLT:  aluop = ALU_SLT;
               default: valid = 1'b0;
            endcase
         end
         default: aluop = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: 2-5 cycles per instruction, no backpressure.
// Outputs decode from the state register; pcen also ANDs the live zero flag.
module mips_mc_controller
   import mips_pkg::*;
#(
   parameter logic TRAP_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [3:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   state_t     state;
   alu_class_t alu_class;
   logic [3:0] dec_aluop;
   logic       funct_valid;
   ctrl_t      ctrl;
   ctrl_t      ctrl_g;

   assign alu_class = (state == S_RTYPEEX) ? AC_FUNCT :
                      (state == S_BEQEX)   ? AC_SUB   : AC_ADD;

   alu_decoder u_alu_decoder (
      .alu_class (alu_class),
      .funct     (funct),
      .aluop     (dec_aluop),
      .valid     (funct_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_RTYPEEX;
                  OP_BEQ:       state <= S_BEQEX;
                  OP_ADDI:      state <= S_ADDIEX;
                  OP_J:         state <= S_JEX;
                  default:      state <= S_FETCH;
               endcase
            end
            // Only LW and SW reach MEMADR, so one compare picks the path.
            S_MEMADR:  state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state <= S_MEMWB;
            S_RTYPEEX: state <= funct_valid ? S_RTYPEWB : S_FETCH;
            S_ADDIEX:  state <= S_ADDIWB;
            default:   state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.irwrite = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.pcsrc   = PC_ALU;
            ctrl.pcwrite = 1'b1;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMM_SH;
            ctrl.illegal = TRAP_ILLEGAL & ~opcode_legal(opcode);
         end
         S_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.illegal = TRAP_ILLEGAL & ~funct_valid;
         end
         S_RTYPEWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.pcsrc   = PC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_JEX: begin
            ctrl.pcsrc   = PC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // Holding reset forces every strobe and select low, even though FETCH is active.
   assign ctrl_g     = reset_n ? ctrl : '0;
   assign aluop      = reset_n ? dec_aluop : ALU_ADD;
   assign alusrca    = ctrl_g.alusrca;
   assign alusrcb    = ctrl_g.alusrcb;
   assign pcsrc      = ctrl_g.pcsrc;
   assign pcen       = ctrl_g.pcwrite | (ctrl_g.branch & zero);
   assign iord       = ctrl_g.iord;
   assign memwrite   = ctrl_g.memwrite;
   assign irwrite    = ctrl_g.irwrite;
   assign regdst     = ctrl_g.regdst;
   assign memtoreg   = ctrl_g.memtoreg;
   assign regwrite   = ctrl_g.regwrite;
   assign illegal_op = ctrl_g.illegal;
   assign state_dbg  = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: per-instruction cycle timelines
// are queued at issue time and a negedge monitor compares the DUT against them.
module tb_mips_mc_controller;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       illegal;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic [3:0] aluop;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       illegal_op;
   logic [3:0] state_dbg;

   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;
   obs_t exp_q[$];
   logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

   mips_mc_controller #(.TRAP_ILLEGAL(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .aluop      (aluop),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.st = state_dbg;     o.aluop = aluop;       o.alusrca = alusrca;
      o.alusrcb = alusrcb;  o.pcsrc = pcsrc;       o.pcen = pcen;
      o.iord = iord;        o.memwrite = memwrite; o.irwrite = irwrite;
      o.regdst = regdst;    o.memtoreg = memtoreg; o.regwrite = regwrite;
      o.illegal = illegal_op;
      return o;
   endfunction

   function automatic obs_t blank(input int st);
      obs_t o;
      o = '0;
      o.st = 4'(st);
      return o;
   endfunction

   task automatic chk(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
                  name, act, act.st, exp, exp.st, $time);
      end
   endtask

   // Expected cycle-by-cycle timeline of one instruction, starting in FETCH.
   task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic z);
      obs_t c;
      int   n;
      n = 0;
      opcode = op;
      funct  = f;
      zero   = z;
      c = blank(0); c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcen = 1'b1;
      exp_q.push_back(c); n++;
      c = blank(1); c.alusrcb = 2'b11;
      c.illegal = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      exp_q.push_back(c); n++;
      if (op == OP_LW || op == OP_SW) begin
         c = blank(2); c.alusrca = 1'b1; c.alusrcb = 2'b10;
         exp_q.push_back(c); n++;
         if (op == OP_LW) begin
            c = blank(3); c.iord = 1'b1;
            exp_q.push_back(c); n++;
            c = blank(4); c.memtoreg = 1'b1; c.regwrite = 1'b1;
            exp_q.push_back(c); n++;
         end else begin
            c = blank(5); c.iord = 1'b1; c.memwrite = 1'b1;
            exp_q.push_back(c); n++;
         end
      end else if (op == OP_R) begin
         c = blank(6); c.alusrca = 1'b1;
         if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a}) begin
            c.aluop = 4'(f - 6'd32);
            exp_q.push_back(c); n++;
            c = blank(7); c.regdst = 1'b1; c.regwrite = 1'b1;
            exp_q.push_back(c); n++;
         end else begin
            c.illegal = 1'b1;
            exp_q.push_back(c); n++;
         end
      end else if (op == OP_BEQ) begin
         c = blank(8); c.alusrca = 1'b1; c.aluop = 4'b0010; c.pcsrc = 2'b01; c.pcen = z;
         exp_q.push_back(c); n++;
      end else if (op == OP_ADDI) begin
         c = blank(9); c.alusrca = 1'b1; c.alusrcb = 2'b10;
         exp_q.push_back(c); n++;
         c = blank(10); c.regwrite = 1'b1;
         exp_q.push_back(c); n++;
      end else if (op == OP_J) begin
         c = blank(11); c.pcsrc = 2'b10; c.pcen = 1'b1;
         exp_q.push_back(c); n++;
      end
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         chk("cycle", sample(), e);
      end
   end

   initial begin
      obs_t c;
      logic [5:0] op;
      logic [5:0] f;
      reset_n = 1'b0;
      opcode  = OP_SW;
      funct   = 6'h00;
      zero    = 1'b0;

      @(posedge clk);
      #1;
      chk("reset_held", sample(), blank(0));
      reset_n = 1'b1;
      #1;
      c = blank(0); c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcen = 1'b1;
      chk("fetch_after_reset", sample(), c);
      repeat (3) @(posedge clk);
      #1;
      c = blank(5); c.iord = 1'b1; c.memwrite = 1'b1;
      chk("memwr_before_reset", sample(), c);
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_mid_memwr", sample(), blank(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      for (int i = 0; i < 7; i++) issue(OP_R, fn_tab[i], 1'b0);
      issue(OP_LW, 6'h00, 1'b0);
      issue(OP_SW, 6'h00, 1'b1);
      issue(OP_BEQ, 6'h00, 1'b1);
      issue(OP_BEQ, 6'h00, 1'b0);
      issue(OP_J, 6'h00, 1'b1);
      issue(OP_ADDI, 6'h00, 1'b0);
      issue(6'b111111, 6'h00, 1'b0);
      issue(OP_R, 6'b000111, 1'b0);

      for (int i = 0; i < 200; i++) begin
         f = fn_tab[$urandom_range(0, 6)];
         case ($urandom_range(0, 7))
            0:       op = OP_R;
            1:       op = OP_LW;
            2:       op = OP_SW;
            3:       op = OP_BEQ;
            4:       op = OP_ADDI;
            5:       op = OP_J;
            6:       op = 6'($urandom_range(0, 63));
            default: begin op = OP_R; f = 6'($urandom_range(0, 63)); end
         endcase
         issue(op, f, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
